// File: rtl/gpca_pkg.sv
// gpca_pkg: op codes, field widths and fixed operand constants shared by the gpca sequencer.
package gpca_pkg;
    typedef enum logic [1:0] {OP_MUL = 2'd0, OP_SQR = 2'd1, OP_SQRT = 2'd2, OP_DIV = 2'd3} op_e;
    typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_e;
    localparam int P_W  = 5;
    localparam int BC_W = 7;
    localparam int A_W  = 10;
    localparam int F_W  = 5;
    localparam int S_W  = 11;
    localparam logic [BC_W-1:0] ROOT_B = 7'b0011111;
    localparam logic [BC_W-1:0] ROOT_C = 7'b0100000;
endpackage

// File: rtl/gpca_fmt.sv
// gpca_fmt: maps an operation request onto the array's X/P/B/C/A justified formats and flags illegal requests.
module gpca_fmt
    import gpca_pkg::*;
(
    input  logic [1:0]      op,
    input  logic [A_W-1:0]  a,
    input  logic [2:0]      b,
    output logic            x,
    output logic [P_W-1:0]  p,
    output logic [BC_W-1:0] bv,
    output logic [BC_W-1:0] cv,
    output logic [A_W-1:0]  av,
    output logic            illegal
);
    op_e             o;
    logic            prod;
    logic [BC_W-1:0] bs;
    assign o    = op_e'(op);
    assign prod = (o == OP_MUL) || (o == OP_SQR);
    assign bs   = {b, 4'b0000};
    always_comb begin
        x       = !prod;
        p       = prod ? a[P_W-1:0] : '0;
        bv      = (o == OP_MUL || o == OP_DIV) ? bs : ROOT_B;
        cv      = (o == OP_MUL || o == OP_DIV) ? bs : ROOT_C;
        // radicand is right-justified, dividend left-justified
        av      = (o == OP_SQRT) ? a : (o == OP_DIV) ? {a[5:0], 4'b0000} : '0;
        illegal = (o == OP_DIV && (b == 3'd0 || a > 10'd63)) || (prod && a > 10'd31);
    end
endmodule

// File: rtl/gpca_seq.sv
// gpca_seq: accepts an op request, drives the gpca array for a settle window, then returns the captured F/S.
module gpca_seq
    import gpca_pkg::*;
#(
    parameter int SETTLE_CYCLES = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [1:0]   req_op,
    input  logic [9:0]   req_a,
    input  logic [2:0]   req_b,
    output logic         res_valid,
    input  logic         res_ready,
    output logic [4:0]   res_f,
    output logic [10:0]  res_s,
    output logic         res_err,
    output logic         g_x,
    output logic [1:5]   g_p,
    output logic [1:7]   g_b,
    output logic [1:7]   g_c,
    output logic [1:10]  g_a,
    input  logic [1:5]   g_f,
    input  logic [1:11]  g_s
);
    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);
    state_e          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            req_ready_q, req_ready_d, res_valid_q, res_valid_d, res_err_q, res_err_d;
    logic [F_W-1:0]  res_f_q, res_f_d;
    logic [S_W-1:0]  res_s_q, res_s_d;
    logic            g_x_q, g_x_d, f_x, f_illegal;
    logic [P_W-1:0]  g_p_q, g_p_d, f_p;
    logic [BC_W-1:0] g_b_q, g_b_d, g_c_q, g_c_d, f_b, f_c;
    logic [A_W-1:0]  g_a_q, g_a_d, f_a;

    gpca_fmt u_fmt (
        .op(req_op), .a(req_a), .b(req_b),
        .x(f_x), .p(f_p), .bv(f_b), .cv(f_c), .av(f_a), .illegal(f_illegal)
    );

    always_comb begin
        state_d = state_q;
        cnt_d = cnt_q;
        req_ready_d = req_ready_q;
        res_valid_d = res_valid_q;
        res_err_d = res_err_q;
        res_f_d = res_f_q;
        res_s_d = res_s_q;
        g_x_d = g_x_q;
        g_p_d = g_p_q;
        g_b_d = g_b_q;
        g_c_d = g_c_q;
        g_a_d = g_a_q;
        case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
                req_ready_d = 1'b0;
                if (f_illegal) begin
                    state_d = DONE;
                    res_valid_d = 1'b1;
                    res_err_d = 1'b1;
                    res_f_d = '0;
                    res_s_d = '0;
                end else begin
                    state_d = SETTLE;
                    cnt_d = CNT_INIT;
                    g_x_d = f_x;
                    g_p_d = f_p;
                    g_b_d = f_b;
                    g_c_d = f_c;
                    g_a_d = f_a;
                end
            end
            SETTLE: if (cnt_q == 4'd0) begin
                state_d = DONE;
                res_valid_d = 1'b1;
                res_err_d = 1'b0;
                res_f_d = g_f;
                res_s_d = g_s;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
            DONE: if (res_ready) begin
                state_d = IDLE;
                res_valid_d = 1'b0;
                req_ready_d = 1'b1;
                g_x_d = 1'b0;
                g_p_d = '0;
                g_b_d = '0;
                g_c_d = '0;
                g_a_d = '0;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q <= '0;
            req_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_err_q <= 1'b0;
            res_f_q <= '0;
            res_s_q <= '0;
            g_x_q <= 1'b0;
            g_p_q <= '0;
            g_b_q <= '0;
            g_c_q <= '0;
            g_a_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            req_ready_q <= req_ready_d;
            res_valid_q <= res_valid_d;
            res_err_q <= res_err_d;
            res_f_q <= res_f_d;
            res_s_q <= res_s_d;
            g_x_q <= g_x_d;
            g_p_q <= g_p_d;
            g_b_q <= g_b_d;
            g_c_q <= g_c_d;
            g_a_q <= g_a_d;
        end
    end

    assign req_ready = req_ready_q;
    assign res_valid = res_valid_q;
    assign res_err = res_err_q;
    assign res_f = res_f_q;
    assign res_s = res_s_q;
    assign g_x = g_x_q;
    assign g_p = g_p_q;
    assign g_b = g_b_q;
    assign g_c = g_c_q;
    assign g_a = g_a_q;
endmodule

// File: tb/tb_gpca_seq.sv
// tb_gpca_seq: randomized check of gpca_seq (SETTLE_CYCLES 4 and 1 side by side) against an arithmetic model.
module tb_gpca_seq;
    localparam int S = 4;
    logic clk = 1'b0;
    logic rst_n, req_valid, res_ready;
    logic [1:0] req_op;
    logic [9:0] req_a;
    logic [2:0] req_b;
    logic [1:5] g_f;
    logic [1:11] g_s;
    logic req_ready0, res_valid0, res_err0, g_x0, req_ready1, res_valid1, res_err1, g_x1;
    logic [4:0] res_f0, res_f1;
    logic [10:0] res_s0, res_s1;
    logic [1:5] g_p0, g_p1;
    logic [1:7] g_b0, g_c0, g_b1, g_c1;
    logic [1:10] g_a0, g_a1;
    logic [29:0] drive0, drive1;
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;
    assign drive0 = {g_x0, g_p0, g_b0, g_c0, g_a0};
    assign drive1 = {g_x1, g_p1, g_b1, g_c1, g_a1};

    gpca_seq #(.SETTLE_CYCLES(S)) u0 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready0),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .res_valid(res_valid0),
        .res_ready(res_ready), .res_f(res_f0), .res_s(res_s0), .res_err(res_err0),
        .g_x(g_x0), .g_p(g_p0), .g_b(g_b0), .g_c(g_c0), .g_a(g_a0), .g_f(g_f), .g_s(g_s)
    );
    gpca_seq #(.SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready1),
        .req_op(req_op), .req_a(req_a), .req_b(req_b), .res_valid(res_valid1),
        .res_ready(res_ready), .res_f(res_f1), .res_s(res_s1), .res_err(res_err1),
        .g_x(g_x1), .g_p(g_p1), .g_b(g_b1), .g_c(g_c1), .g_a(g_a1), .g_f(g_f), .g_s(g_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [29:0] exp_drive(input int op, input int a, input int b);
        int p, bb, cc, av;
        p = (op < 2) ? a : 0;
        bb = (op == 0 || op == 3) ? b * 16 : 31;
        cc = (op == 0 || op == 3) ? b * 16 : 32;
        av = (op == 2) ? a : (op == 3) ? a * 16 : 0;
        return {op >= 2, 5'(p), 7'(bb), 7'(cc), 10'(av)};
    endfunction

    task automatic scramble();
        g_f = 5'($urandom);
        g_s = 11'($urandom);
        req_op = 2'($urandom);
        req_a = 10'($urandom);
        req_b = 3'($urandom);
    endtask

    task automatic run_op(input int op, input int a, input int b, input int hold);
        bit bad;
        logic [29:0] ed;
        logic [4:0] ef, ef1;
        logic [10:0] es, es1;
        bad = (op == 3 && (b == 0 || a > 63)) || (op < 2 && a > 31);
        ed = bad ? 30'd0 : exp_drive(op, a, b);
        ef = 0; es = 0; ef1 = 0; es1 = 0;
        @(negedge clk);
        check("req_ready_idle", req_ready0, 1);
        req_valid = 1'b1; req_op = 2'(op); req_a = 10'(a); req_b = 3'(b); res_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("req_ready_busy", req_ready0, 0);
        if (bad) begin
            check("err_valid", res_valid0, 1);
            check("err_flag", res_err0, 1);
            check("err_fs", {res_f0, res_s0}, 0);
            check("err_drive", drive0, 0);
            check("err_valid_s1", {res_valid1, res_err1}, 2'b11);
        end else begin
            check("drive_load", drive0, ed);
            check("drive_load_s1", drive1, ed);
            for (int k = 1; k <= S; k++) begin
                @(negedge clk);
                scramble();
                if (k == 1) begin ef1 = g_f; es1 = g_s; end
                ef = g_f; es = g_s;
                @(posedge clk); #1;
                check("valid_latency", res_valid0, k == S);
                check("req_ready_settle", req_ready0, 0);
                check("drive_hold", drive0, ed);
                check("drive_hold_s1", drive1, ed);
                if (k == 1) begin
                    check("valid_s1", res_valid1, 1);
                    check("capture_s1", {res_err1, res_f1, res_s1}, {1'b0, ef1, es1});
                end
            end
            check("capture", {res_err0, res_f0, res_s0}, {1'b0, ef, es});
        end
        repeat (hold) begin
            @(negedge clk);
            scramble();
            @(posedge clk); #1;
            check("done_valid", {res_valid0, res_valid1, req_ready0}, 3'b110);
            check("done_res", {res_err0, res_f0, res_s0}, {bad, ef, es});
            check("done_res_s1", {res_f1, res_s1}, {ef1, es1});
            check("done_drive", drive0, ed);
            check("done_drive_s1", drive1, ed);
        end
        @(negedge clk);
        res_ready = 1'b1;
        @(posedge clk); #1;
        check("return_valid", {res_valid0, res_valid1}, 0);
        check("return_ready", {req_ready0, req_ready1}, 2'b11);
        check("return_drive", {drive0, drive1}, 0);
    endtask

    task automatic mid_reset(input int cycles);
        @(negedge clk);
        req_valid = 1'b1; req_op = 2'd0; req_a = 10'd7; req_b = 3'd3; res_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (cycles - 1) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("areset_ready", {req_ready0, req_ready1}, 2'b11);
        check("areset_valid", {res_valid0, res_valid1}, 0);
        check("areset_drive", {drive0, drive1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1; req_valid = 1'b0; res_ready = 1'b0;
        req_op = 0; req_a = 0; req_b = 0; g_f = 0; g_s = 0;
        #2 rst_n = 1'b0;
        #10;
        check("reset_ready", {req_ready0, req_ready1}, 2'b11);
        check("reset_res", {res_valid0, res_err0, res_f0, res_s0}, 0);
        check("reset_drive", {drive0, drive1}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(0, 5, 7, 0);
        run_op(1, 5, 0, 0);
        run_op(2, 25, 0, 0);
        run_op(3, 35, 5, 6);
        run_op(3, 9, 0, 0);
        run_op(0, 32, 3, 0);
        mid_reset(2);
        mid_reset(S + 1);
        run_op(0, 3, 1, 1);
        for (int i = 0; i < 40; i++) begin
            int op, a;
            op = $urandom_range(0, 3);
            a = (op == 2) ? $urandom_range(0, 1023) : (op == 3) ? $urandom_range(0, 70) : $urandom_range(0, 36);
            run_op(op, a, $urandom_range(0, 7), $urandom_range(0, 3));
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
